// File: rtl/bp_mcore_looper_dev_if.sv
// Command/response bus plus loop-index stream for the looper device.
// Latency: none, this is wiring only.
// Backpressure: cmd uses valid/ready, resp and idx use valid/yumi.
interface bp_mcore_looper_dev_if #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int index_width_p = 32
);
    logic                     cmd_v_i;
    logic                     cmd_ready_o;
    logic                     cmd_w_i;
    logic [paddr_width_p-1:0] cmd_addr_i;
    logic [dword_width_p-1:0] cmd_data_i;
    logic                     resp_v_o;
    logic                     resp_yumi_i;
    logic                     resp_w_o;
    logic [dword_width_p-1:0] resp_data_o;
    logic                     idx_v_o;
    logic [index_width_p-1:0] idx_o;
    logic                     idx_yumi_i;
    logic                     done_o;

    // Device side
    modport slave (
        input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i, idx_yumi_i,
        output cmd_ready_o, resp_v_o, resp_w_o, resp_data_o, idx_v_o, idx_o, done_o
    );

    // Host / consumer side
    modport master (
        output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i, idx_yumi_i,
        input  cmd_ready_o, resp_v_o, resp_w_o, resp_data_o, idx_v_o, idx_o, done_o
    );
endinterface

// File: rtl/bp_mcore_looper_dev.sv
// Memory-mapped loop generator: emits indices max(LSTART,GSTART) .. min(LEND,GEND)-1.
// Latency: response one cycle after command acceptance; first index one cycle after start.
// Backpressure: single response slot (cmd_ready = ~resp_v); index stream held until yumi.
module bp_mcore_looper_dev #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int index_width_p = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_mcore_looper_dev_if.slave  bus
);
    localparam logic [paddr_width_p-1:0] ADDR_CTRL   = paddr_width_p'(32'h0050_0000);
    localparam logic [paddr_width_p-1:0] ADDR_GSTART = paddr_width_p'(32'h0050_0008);
    localparam logic [paddr_width_p-1:0] ADDR_GEND   = paddr_width_p'(32'h0050_0010);
    localparam logic [paddr_width_p-1:0] ADDR_LSTART = paddr_width_p'(32'h0050_0018);
    localparam logic [paddr_width_p-1:0] ADDR_LEND   = paddr_width_p'(32'h0050_0020);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                   state;
    logic [index_width_p-1:0] gstart, gend, lstart, lend;
    logic [index_width_p-1:0] idx, eff_end;
    logic                     done;
    logic                     resp_v, resp_w;
    logic [dword_width_p-1:0] resp_data;

    logic                     accept, wr, hit_ctrl;
    logic                     start_wr, abort_wr, clr_wr;
    logic [index_width_p-1:0] wdata_idx, eff_start_c, eff_end_c;
    logic [index_width_p:0]   idx_next;
    logic [dword_width_p-1:0] rdata;
    logic                     unused_data;

    assign accept    = bus.cmd_v_i & ~resp_v;
    assign wr        = accept & bus.cmd_w_i;
    assign hit_ctrl  = (bus.cmd_addr_i == ADDR_CTRL);
    assign wdata_idx = bus.cmd_data_i[index_width_p-1:0];

    // Abort outranks start in the same write; a plain write (neither bit) clears done.
    assign abort_wr  = wr & hit_ctrl & bus.cmd_data_i[3];
    assign start_wr  = wr & hit_ctrl & bus.cmd_data_i[0] & ~bus.cmd_data_i[3];
    assign clr_wr    = wr & hit_ctrl & ~bus.cmd_data_i[0] & ~bus.cmd_data_i[3];

    assign eff_start_c = (lstart > gstart) ? lstart : gstart;
    assign eff_end_c   = (lend < gend) ? lend : gend;

    // One extra bit so the end test can never be fooled by wraparound.
    assign idx_next    = {1'b0, idx} + (index_width_p+1)'(1);

    assign unused_data = ^bus.cmd_data_i;

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rdata = '0;
        case (bus.cmd_addr_i)
            ADDR_CTRL: begin
                rdata[2] = done;
                rdata[1] = (state == RUN);
            end
            ADDR_GSTART: rdata[index_width_p-1:0] = gstart;
            ADDR_GEND:   rdata[index_width_p-1:0] = gend;
            ADDR_LSTART: rdata[index_width_p-1:0] = lstart;
            ADDR_LEND:   rdata[index_width_p-1:0] = lend;
            default:     rdata = '0;
        endcase
    end

    // One-entry response buffer, held stable until consumed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v    <= 1'b0;
            resp_w    <= 1'b0;
            resp_data <= '0;
        end else if (accept) begin
            resp_v    <= 1'b1;
            resp_w    <= bus.cmd_w_i;
            resp_data <= bus.cmd_w_i ? '0 : rdata;
        end else if (bus.resp_yumi_i) begin
            resp_v    <= 1'b0;
        end
    end

    // Bound registers; frozen while a loop is running.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            gstart <= '0;
            gend   <= '0;
            lstart <= '0;
            lend   <= '0;
        end else if (wr && state == IDLE) begin
            if (bus.cmd_addr_i == ADDR_GSTART) gstart <= wdata_idx;
            if (bus.cmd_addr_i == ADDR_GEND)   gend   <= wdata_idx;
            if (bus.cmd_addr_i == ADDR_LSTART) lstart <= wdata_idx;
            if (bus.cmd_addr_i == ADDR_LEND)   lend   <= wdata_idx;
        end
    end

    // Loop FSM: latches effective bounds at start, steps idx on each consume.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            idx     <= '0;
            eff_end <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_wr) begin
                        idx     <= eff_start_c;
                        eff_end <= eff_end_c;
                        if (eff_start_c >= eff_end_c) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            state <= RUN;
                        end
                    end else if (clr_wr) begin
                        done <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_wr) begin
                        state <= IDLE;
                    end else if (bus.idx_yumi_i) begin
                        idx <= idx_next[index_width_p-1:0];
                        if (idx_next == {1'b0, eff_end}) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = ~resp_v;
    assign bus.resp_v_o    = resp_v;
    assign bus.resp_w_o    = resp_w;
    assign bus.resp_data_o = resp_data;
    assign bus.idx_v_o     = (state == RUN);
    assign bus.idx_o       = idx;
    assign bus.done_o      = done;
endmodule

// File: tb/tb_bp_mcore_looper_dev.sv
// Directed bench for the looper device.
// Latency: drives on negedge, samples on negedge.
// Backpressure: holds resp_yumi low to exercise the single response slot.
module tb_bp_mcore_looper_dev;
    localparam logic [39:0] A_CTRL   = 40'h50_0000;
    localparam logic [39:0] A_GSTART = 40'h50_0008;
    localparam logic [39:0] A_GEND   = 40'h50_0010;
    localparam logic [39:0] A_LSTART = 40'h50_0018;
    localparam logic [39:0] A_LEND   = 40'h50_0020;
    localparam logic [39:0] A_UNMAP  = 40'h50_0030;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bp_mcore_looper_dev_if #(.paddr_width_p(40), .dword_width_p(64), .index_width_p(32)) bus ();

    bp_mcore_looper_dev #(.paddr_width_p(40), .dword_width_p(64), .index_width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, check its response one cycle later, consume it.
    task automatic xact(input string tag, input logic w, input logic [39:0] addr,
                        input logic [63:0] data, input logic [63:0] exp_rd);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(bus.cmd_ready_o), 64'd1);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_w_i    = w;
        bus.cmd_addr_i = addr;
        bus.cmd_data_i = data;
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
        chk({tag, "_rv"}, 64'(bus.resp_v_o), 64'd1);
        chk({tag, "_rw"}, 64'(bus.resp_w_o), 64'(w));
        chk({tag, "_rd"}, bus.resp_data_o, w ? 64'd0 : exp_rd);
        bus.resp_yumi_i = 1'b1;
        @(negedge clk);
        bus.resp_yumi_i = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [39:0] addr, input logic [63:0] data);
        xact(tag, 1'b1, addr, data, 64'd0);
    endtask

    task automatic rd(input string tag, input logic [39:0] addr, input logic [63:0] exp);
        xact(tag, 1'b0, addr, 64'hDEAD_BEEF, exp);
    endtask

    // Consume every index offered (bounded), checking sequence, count and done.
    task automatic drain(input string tag, input logic [31:0] first, input int count);
        int n = 0;
        logic [31:0] e = first;
        for (int k = 0; k < count + 4; k++) begin
            if (!bus.idx_v_o) break;
            chk({tag, "_idx"}, 64'(bus.idx_o), 64'(e));
            e++;
            n++;
            bus.idx_yumi_i = 1'b1;
            @(negedge clk);
        end
        bus.idx_yumi_i = 1'b0;
        chk({tag, "_count"}, 64'(n), 64'(count));
        chk({tag, "_done"}, 64'(bus.done_o), 64'd1);
        chk({tag, "_vlow"}, 64'(bus.idx_v_o), 64'd0);
    endtask

    // Consume exactly k indices starting at first.
    task automatic consume(input string tag, input logic [31:0] first, input int k);
        for (int i = 0; i < k; i++) begin
            chk({tag, "_v"}, 64'(bus.idx_v_o), 64'd1);
            chk({tag, "_idx"}, 64'(bus.idx_o), 64'(first + 32'(i)));
            bus.idx_yumi_i = 1'b1;
            @(negedge clk);
        end
        bus.idx_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_v_i     = 1'b0;
        bus.cmd_w_i     = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        bus.resp_yumi_i = 1'b0;
        bus.idx_yumi_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_rv",    64'(bus.resp_v_o),    64'd0);
        chk("rst_rd",    bus.resp_data_o,      64'd0);
        chk("rst_rw",    64'(bus.resp_w_o),    64'd0);
        chk("rst_iv",    64'(bus.idx_v_o),     64'd0);
        chk("rst_idx",   64'(bus.idx_o),       64'd0);
        chk("rst_done",  64'(bus.done_o),      64'd0);
        rd("rst_lstart", A_LSTART, 64'd0);

        // Basic loop 5..7
        wr("a_gs", A_GSTART, 64'd0);
        wr("a_ge", A_GEND,   64'd100);
        wr("a_ls", A_LSTART, 64'd5);
        wr("a_le", A_LEND,   64'd8);
        wr("a_go", A_CTRL,   64'd1);
        drain("a", 32'd5, 3);
        rd("a_ctrl", A_CTRL, 64'h4);

        // Abort while idle and abort+start are no-ops; plain write clears done
        wr("b_ab", A_CTRL, 64'h8);
        rd("b_ctrl1", A_CTRL, 64'h4);
        wr("b_sa", A_CTRL, 64'h9);
        chk("b_iv", 64'(bus.idx_v_o), 64'd0);
        rd("b_ctrl2", A_CTRL, 64'h4);
        wr("b_clr", A_CTRL, 64'h0);
        rd("b_ctrl3", A_CTRL, 64'h0);

        // Index registers keep only the low index bits
        wr("c_trunc", A_GEND, 64'h1_0000_0005);
        rd("c_gend", A_GEND, 64'd5);

        // Global bounds clip the local range; writes during RUN ignored
        wr("d_gs", A_GSTART, 64'd10);
        wr("d_ge", A_GEND,   64'd20);
        wr("d_ls", A_LSTART, 64'd0);
        wr("d_le", A_LEND,   64'd50);
        wr("d_go", A_CTRL,   64'd1);
        wr("d_le2", A_LEND,  64'd12);
        wr("d_go2", A_CTRL,  64'd1);
        rd("d_busy", A_CTRL, 64'h2);
        drain("d", 32'd10, 10);
        rd("d_lend", A_LEND, 64'd50);

        // Empty range: done immediately, no index
        wr("e_ls", A_LSTART, 64'd7);
        wr("e_le", A_LEND,   64'd7);
        wr("e_go", A_CTRL,   64'd1);
        chk("e_iv", 64'(bus.idx_v_o), 64'd0);
        chk("e_done", 64'(bus.done_o), 64'd1);
        @(negedge clk);
        chk("e_iv2", 64'(bus.idx_v_o), 64'd0);

        // Single-element range 19..20
        wr("f_ls", A_LSTART, 64'd19);
        wr("f_le", A_LEND,   64'd50);
        wr("f_go", A_CTRL,   64'd1);
        drain("f", 32'd19, 1);

        // Abort mid-run
        wr("g_gs", A_GSTART, 64'd0);
        wr("g_ge", A_GEND,   64'd1000);
        wr("g_ls", A_LSTART, 64'd0);
        wr("g_le", A_LEND,   64'd1000);
        wr("g_go", A_CTRL,   64'd1);
        chk("g_done0", 64'(bus.done_o), 64'd0);
        consume("g", 32'd0, 3);
        chk("g_idx3", 64'(bus.idx_o), 64'd3);
        wr("g_abort", A_CTRL, 64'h8);
        chk("g_iv", 64'(bus.idx_v_o), 64'd0);
        chk("g_done", 64'(bus.done_o), 64'd0);
        rd("g_ctrl", A_CTRL, 64'h0);

        // Unmapped write ignored, unmapped read returns 0
        wr("h_unw", A_UNMAP, 64'd77);
        rd("h_unr", 40'h50_0028, 64'd0);
        rd("h_gend", A_GEND, 64'd1000);

        // Held response: stable, no new command accepted
        @(negedge clk);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_w_i    = 1'b0;
        bus.cmd_addr_i = A_UNMAP;
        @(negedge clk);
        bus.cmd_addr_i = A_GEND;
        for (int i = 0; i < 5; i++) begin
            chk("i_rv",    64'(bus.resp_v_o),    64'd1);
            chk("i_ready", 64'(bus.cmd_ready_o), 64'd0);
            chk("i_rd",    bus.resp_data_o,      64'd0);
            chk("i_rw",    64'(bus.resp_w_o),    64'd0);
            @(negedge clk);
        end
        bus.cmd_v_i     = 1'b0;
        bus.resp_yumi_i = 1'b1;
        @(negedge clk);
        bus.resp_yumi_i = 1'b0;
        chk("i_rv_end",    64'(bus.resp_v_o),    64'd0);
        chk("i_ready_end", 64'(bus.cmd_ready_o), 64'd1);

        // Asynchronous reset mid-run with a pending response
        wr("j_ls", A_LSTART, 64'd3);
        wr("j_go", A_CTRL,   64'd1);
        consume("j", 32'd3, 2);
        @(negedge clk);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_w_i    = 1'b0;
        bus.cmd_addr_i = A_GEND;
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
        chk("j_rv_pre", 64'(bus.resp_v_o), 64'd1);
        chk("j_iv_pre", 64'(bus.idx_v_o),  64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("j_rv_rst",    64'(bus.resp_v_o),    64'd0);
        chk("j_iv_rst",    64'(bus.idx_v_o),     64'd0);
        chk("j_ready_rst", 64'(bus.cmd_ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("j_iv_post", 64'(bus.idx_v_o), 64'd0);
        chk("j_rv_post", 64'(bus.resp_v_o), 64'd0);
        rd("j_lstart", A_LSTART, 64'd0);
        rd("j_gend",   A_GEND,   64'd0);
        rd("j_ctrl",   A_CTRL,   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
